// File: rtl/muldiv_hilo_if.sv
// Bundle of the EX-stage signals that talk to the multiply/divide unit:
// the operation launch, mthi/mtlo writes, and the HI/LO/busy results.
interface muldiv_hilo_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        we;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, d1, d2, we, hilo_sel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, d1, d2, we, hilo_sel,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// MIPS-style HI/LO multiply/divide unit: the result is computed when the
// operation starts, held in pending registers and committed after a fixed latency.
module muldiv_hilo #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_hilo_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      p_hi_reg, p_hi_next;
  logic [31:0]      p_lo_reg, p_lo_next;
  logic             p_valid_reg, p_valid_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             busy_reg, busy_next;

  logic        is_signed;
  logic        is_div;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic        div_zero;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = ~bus.op[0];
  assign is_div    = bus.op[1];

  // Sign/zero extension to 64 bits makes one unsigned multiplier serve both forms.
  assign mul_a = {{32{is_signed & bus.d1[31]}}, bus.d1};
  assign mul_b = {{32{is_signed & bus.d2[31]}}, bus.d2};
  assign prod  = mul_a * mul_b;

  // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg    = is_signed & bus.d1[31];
  assign b_neg    = is_signed & bus.d2[31];
  assign a_mag    = a_neg ? (32'd0 - bus.d1) : bus.d1;
  assign b_mag    = b_neg ? (32'd0 - bus.d2) : bus.d2;
  assign div_zero = (bus.d2 == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      p_hi_reg    <= '0;
      p_lo_reg    <= '0;
      p_valid_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      p_hi_reg    <= p_hi_next;
      p_lo_reg    <= p_lo_next;
      p_valid_reg <= p_valid_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    p_hi_next    = p_hi_reg;
    p_lo_next    = p_lo_reg;
    p_valid_next = p_valid_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    busy_next    = busy_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          p_hi_next    = is_div ? rem  : prod[63:32];
          p_lo_next    = is_div ? quot : prod[31:0];
          p_valid_next = ~(is_div & div_zero);
          cnt_next     = is_div ? DIV_LOAD : MUL_LOAD;
          state_next   = RUN;
          busy_next    = 1'b1;
        end else if (bus.we) begin
          if (bus.hilo_sel) lo_next = bus.d1;
          else              hi_next = bus.d1;
        end
      end
      RUN: begin
        // start and we are deliberately not looked at here, including the final edge.
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg <= CNT_ONE) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          if (p_valid_reg) begin
            hi_next = p_hi_reg;
            lo_next = p_lo_reg;
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases, collisions,
// asynchronous reset and randomized operations against an arithmetic model.
module tb_muldiv_hilo;

  localparam int MUL = 5;
  localparam int DIV = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_hilo_if bus_if();

  muldiv_hilo #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    logic [63:0] qv;
    logic [63:0] rv;
    if (o[0]) begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (!o[1]) begin
      p = 64'(sa * sb);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b != 32'd0) begin
      q = sa / sb;
      r = sa % sb;
      qv = 64'(q);
      rv = 64'(r);
      exp_lo = qv[31:0];
      exp_hi = rv[31:0];
    end
  endfunction

  task automatic write_reg(input logic sel, input logic [31:0] v);
    @(negedge clk);
    bus_if.we = 1'b1;
    bus_if.hilo_sel = sel;
    bus_if.d1 = v;
    @(negedge clk);
    bus_if.we = 1'b0;
    if (sel) exp_lo = v;
    else     exp_hi = v;
  endtask

  // Launches one operation and measures busy length and HI/LO stability.
  task automatic exec_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic with_we, output int cycles, output logic stable);
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clk);
    h0 = bus_if.hi;
    l0 = bus_if.lo;
    bus_if.start = 1'b1;
    bus_if.op = o;
    bus_if.d1 = a;
    bus_if.d2 = b;
    bus_if.we = with_we;
    bus_if.hilo_sel = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.we = 1'b0;
    bus_if.d1 = $urandom;
    bus_if.d2 = $urandom;
    cycles = 0;
    stable = 1'b1;
    while (bus_if.busy && cycles < 200) begin
      cycles++;
      if (bus_if.hi !== h0 || bus_if.lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
    $display("op=%0d d1=%h d2=%h busy_cycles=%0d hi=%h lo=%h", o, a, b, cycles, bus_if.hi, bus_if.lo);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    checks++; if (bus_if.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", bus_if.hi); end
    checks++; if (bus_if.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", bus_if.lo); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) begin
      errors++; $display("FAIL reset_release: got busy=%b hi=%h lo=%h want 0/0/0", bus_if.busy, bus_if.hi, bus_if.lo);
    end
    exp_hi = 32'h0;
    exp_lo = 32'h0;
  endtask

  task automatic test_mthilo;
    write_reg(1'b0, 32'hCAFE0001);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", bus_if.busy); end
    checks++; if (bus_if.hi !== 32'hCAFE0001) begin errors++; $display("FAIL mthi_hi: got %h want cafe0001", bus_if.hi); end
    write_reg(1'b1, 32'hBEEF0002);
    checks++; if (bus_if.lo !== 32'hBEEF0002 || bus_if.hi !== 32'hCAFE0001) begin
      errors++; $display("FAIL mtlo: got hi=%h lo=%h want cafe0001/beef0002", bus_if.hi, bus_if.lo);
    end
    $display("mthi/mtlo hi=%h lo=%h", bus_if.hi, bus_if.lo);
  endtask

  task automatic test_directed;
    int   cyc;
    logic st;
    exec_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, cyc, st);
    checks++; if (cyc !== MUL) begin errors++; $display("FAIL mult_busy: got %0d want %0d", cyc, MUL); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_stable: got %b want 1", st); end
    checks++; if (bus_if.hi !== 32'hFFFFFFFF || bus_if.lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffffa", bus_if.hi, bus_if.lo);
    end
    exec_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, cyc, st);
    checks++; if (cyc !== MUL || bus_if.hi !== 32'h1 || bus_if.lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu: got cyc=%0d %h_%h want %0d 00000001_fffffffe", cyc, bus_if.hi, bus_if.lo, MUL);
    end
    exec_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, st);
    checks++; if (cyc !== DIV || st !== 1'b1) begin errors++; $display("FAIL div_busy: got cyc=%0d stable=%b want %0d 1", cyc, st, DIV); end
    checks++; if (bus_if.hi !== 32'hFFFFFFFF || bus_if.lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_result: got hi=%h lo=%h want ffffffff/fffffffd", bus_if.hi, bus_if.lo);
    end
    exec_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, st);
    checks++; if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h80000000) begin
      errors++; $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", bus_if.hi, bus_if.lo);
    end
    write_reg(1'b0, 32'h11);
    write_reg(1'b1, 32'h22);
    exec_op(2'b11, 32'h12345678, 32'h0, 1'b0, cyc, st);
    checks++; if (cyc !== DIV) begin errors++; $display("FAIL divzero_busy: got %0d want %0d", cyc, DIV); end
    checks++; if (bus_if.hi !== 32'h11 || bus_if.lo !== 32'h22) begin
      errors++; $display("FAIL divzero_keep: got hi=%h lo=%h want 00000011/00000022", bus_if.hi, bus_if.lo);
    end
  endtask

  task automatic test_collision;
    int          cyc;
    logic        st;
    logic [31:0] h0;
    logic [31:0] l0;
    model_op(2'b10, 32'd100, 32'd7);
    @(negedge clk);
    h0 = bus_if.hi;
    l0 = bus_if.lo;
    bus_if.start = 1'b1; bus_if.op = 2'b10; bus_if.d1 = 32'd100; bus_if.d2 = 32'd7;
    @(negedge clk);
    bus_if.start = 1'b0;
    cyc = 0;
    st = 1'b1;
    while (bus_if.busy && cyc < 200) begin
      cyc++;
      if (bus_if.hi !== h0 || bus_if.lo !== l0) st = 1'b0;
      bus_if.start = (cyc == 2);
      bus_if.op = 2'b00; bus_if.d1 = 32'hDEAD0000; bus_if.d2 = 32'd3;
      bus_if.we = (cyc == 2 || cyc == 5);
      bus_if.hilo_sel = (cyc == 5);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    bus_if.we = 1'b0;
    $display("collision div busy_cycles=%0d hi=%h lo=%h", cyc, bus_if.hi, bus_if.lo);
    checks++; if (cyc !== DIV || st !== 1'b1) begin errors++; $display("FAIL collide_busy: got cyc=%0d stable=%b want %0d 1", cyc, st, DIV); end
    checks++; if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
      errors++; $display("FAIL collide_result: got %h_%h want %h_%h", bus_if.hi, bus_if.lo, exp_hi, exp_lo);
    end
    repeat (2) @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL collide_no_restart: got busy=%b want 0", bus_if.busy); end
    model_op(2'b01, 32'h00001234, 32'h10);
    exec_op(2'b01, 32'h00001234, 32'h10, 1'b1, cyc, st);
    checks++; if (cyc !== MUL || bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
      errors++; $display("FAIL start_and_we: got cyc=%0d %h_%h want %0d %h_%h", cyc, bus_if.hi, bus_if.lo, MUL, exp_hi, exp_lo);
    end
  endtask

  task automatic test_start_at_fall;
    int cyc;
    model_op(2'b00, 32'd7, 32'hFFFFFFFD);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.d1 = 32'd7; bus_if.d2 = 32'hFFFFFFFD;
    @(negedge clk);
    cyc = 0;
    while (bus_if.busy && cyc < 200) begin cyc++; @(negedge clk); end
    checks++; if (cyc !== MUL) begin errors++; $display("FAIL held_start_first: got %0d want %0d", cyc, MUL); end
    checks++; if (bus_if.hi !== 32'hFFFFFFFF || bus_if.lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL held_start_result: got %h_%h want ffffffff_ffffffeb", bus_if.hi, bus_if.lo);
    end
    bus_if.op = 2'b11; bus_if.d1 = 32'd1000; bus_if.d2 = 32'd7;
    model_op(2'b11, 32'd1000, 32'd7);
    @(negedge clk);
    bus_if.start = 1'b0;
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL next_cycle_start: got busy=%b want 1", bus_if.busy); end
    cyc = 0;
    while (bus_if.busy && cyc < 200) begin cyc++; @(negedge clk); end
    $display("held start second op busy_cycles=%0d hi=%h lo=%h", cyc, bus_if.hi, bus_if.lo);
    checks++; if (cyc !== DIV || bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
      errors++; $display("FAIL held_start_second: got cyc=%0d %h_%h want %0d %h_%h", cyc, bus_if.hi, bus_if.lo, DIV, exp_hi, exp_lo);
    end
  endtask

  task automatic test_random;
    int          cyc;
    logic        st;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 14));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        write_reg(1'($urandom_range(0, 1)), $urandom);
        checks++; if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo || bus_if.busy !== 1'b0) begin
          errors++; $display("FAIL rand_write: got %h_%h busy=%b want %h_%h 0", bus_if.hi, bus_if.lo, bus_if.busy, exp_hi, exp_lo);
        end
      end
      model_op(o, a, b);
      exec_op(o, a, b, 1'b0, cyc, st);
      checks++; if (cyc !== (o[1] ? DIV : MUL) || st !== 1'b1) begin
        errors++; $display("FAIL rand_busy[%0d]: got cyc=%0d stable=%b want %0d 1", i, cyc, st, o[1] ? DIV : MUL);
      end
      checks++; if (bus_if.hi !== exp_hi || bus_if.lo !== exp_lo) begin
        errors++; $display("FAIL rand_result[%0d]: got %h_%h want %h_%h", i, bus_if.hi, bus_if.lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic bad;
    write_reg(1'b0, 32'hAAAA5555);
    write_reg(1'b1, 32'h5555AAAA);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.d1 = 32'd9; bus_if.d2 = 32'd9;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("reset mid-op busy=%b hi=%h lo=%h", bus_if.busy, bus_if.hi, bus_if.lo);
    checks++; if (bus_if.busy !== 1'b0 || bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) begin
      errors++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0/0/0", bus_if.busy, bus_if.hi, bus_if.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b0 || bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got busy=%b hi=%h lo=%h want 0/0/0", bus_if.busy, bus_if.hi, bus_if.lo);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    errors = 0;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    bus_if.start = 1'b0;
    bus_if.op = 2'b00;
    bus_if.d1 = 32'h0;
    bus_if.d2 = 32'h0;
    bus_if.we = 1'b0;
    bus_if.hilo_sel = 1'b0;
    test_reset;
    test_mthilo;
    test_directed;
    test_collision;
    test_start_at_fall;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter MUL_CYCLES, default 5: cycles busy is high for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: cycles busy is high for div/divu.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low.
REQ-005 Port start, input, 1: launch an operation selected by op.
REQ-006 Port op, input, 2: operation select.
  - 00 mult (signed)
  - 01 multu
  - 10 div (signed)
  - 11 divu
REQ-007 Port d1, input, 32: rs operand; multiplicand or dividend.
REQ-008 Port d2, input, 32: rt operand; multiplier or divisor.
REQ-009 Port we, input, 1: mthi/mtlo write strobe.
REQ-010 Port hilo_sel, input, 1: target of we; 0 = HI, 1 = LO.
REQ-011 Port busy, output, 1: operation in flight; the EX stage stalls mfhi/mflo/mthi/mtlo and md ops while busy or start.
REQ-012 Port hi, output, 32: architectural HI register.
REQ-013 Port lo, output, 32: architectural LO register.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN, plus a down-counter cnt wide enough for max(MUL_CYCLES, DIV_CYCLES).
REQ-015 Start in IDLE, sampled at edge k:
  - latch the op result into pending registers p_hi/p_lo
  - load cnt with MUL_CYCLES or DIV_CYCLES
  - enter RUN
  - busy = 1 from just after edge k
REQ-016 In RUN, cnt SHALL decrement each edge. At edge k+N (N = selected latency), hi/lo SHALL load p_hi/p_lo, busy SHALL fall and the state SHALL return to IDLE. Busy is therefore high for exactly N cycles.
REQ-017 hi/lo SHALL remain at their old values throughout RUN. Results are never visible before busy falls.
REQ-018 mult SHALL produce the 64-bit two's-complement product of d1 and d2; multu the unsigned product. hi = bits 63:32, lo = bits 31:0.
REQ-019 div SHALL set lo = quotient truncated toward zero and hi = remainder with the sign of the dividend. divu SHALL do the same, unsigned.
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-021 Division by zero (d2 = 0) SHALL leave hi/lo unchanged at completion; busy still lasts DIV_CYCLES.
REQ-022 Start while in RUN SHALL be ignored; the in-flight operation is unaffected.
REQ-023 We in IDLE without start SHALL write d1 to hi (hilo_sel = 0) or lo (hilo_sel = 1) at that edge, with no busy.
REQ-024 We in RUN SHALL be ignored.
REQ-025 Start and we in the same IDLE cycle: start SHALL take priority and we SHALL be ignored.
REQ-026 Start on the same edge busy falls (state RUN) SHALL be ignored. A new start is accepted from the following cycle.
REQ-027 Outputs hi, lo and busy SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-028 While reset = 0, regardless of clk:
  - hi = 0x00000000, lo = 0x00000000
  - busy = 0, state = IDLE, cnt = 0
  - p_hi/p_lo cleared
REQ-029 Reset asserted mid-operation SHALL discard the pending result. After reset deasserts, hi/lo stay 0 and busy stays 0 until a new start.

Verification
REQ-030 Signed multiply: start, op = 00, d1 = 0xFFFFFFFE (-2), d2 = 3 -> busy high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; hi/lo unchanged during busy.
REQ-031 Unsigned multiply: op = 01, d1 = 0xFFFFFFFF, d2 = 2 -> after 5 cycles hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-032 Signed divide: op = 10, d1 = 0xFFFFFFF9 (-7), d2 = 2 -> busy 10 cycles; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-033 Divide by zero: op = 11, d2 = 0, hi/lo preloaded via we (hi = 0x11, lo = 0x22) -> busy 10 cycles; hi = 0x11, lo = 0x22 afterward.
REQ-034 Collisions: start at cycle 3 of a 10-cycle div, and we during RUN -> both ignored; first div result committed at cycle 10. Start and we together in IDLE -> only the operation executes.
REQ-035 Reset mid-operation: pull reset low at cycle 4 of a mult -> busy, hi, lo go to 0 immediately (asynchronously). After release, all remain 0 until the next start.
